// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, IFU state encoding.
package cpu_defs;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    localparam int unsigned PC_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read/busywait bus; master is the fetch unit, slave is the memory.
interface instruction_fetch_unit_if;

    logic        read;
    logic [31:0] addr;
    logic        busywait;
    logic [31:0] readdata;

    modport master (output read, output addr, input busywait, input readdata);
    modport slave  (input read, input addr, output busywait, output readdata);

endinterface

// File: rtl/instruction_fetch_unit_pc_next_calc.sv
// Next-PC adder: sequential step plus optional signed word-offset branch.
// Branching is compiled in only when IFU_BRANCH_EN is defined.
module pc_next_calc #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [7:0]  branch_offset_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] seq_pc;

    assign seq_pc = pc_i + PC_STEP[31:0];

`ifdef IFU_BRANCH_EN
    logic [31:0] offset_bytes;

    // Word offset becomes a byte offset: sign-extend then shift left by two.
    assign offset_bytes = {{22{branch_offset_i[7]}}, branch_offset_i, 2'b00};
    assign next_pc_o    = branch_taken_i ? (seq_pc + offset_bytes) : seq_pc;
`else
    logic unused_branch;

    assign unused_branch = branch_taken_i ^ (^branch_offset_i);
    assign next_pc_o     = seq_pc;
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: holds PC, fetches over the imem handshake, issues decoded fields.
// Optional branch redirect via macro IFU_BRANCH_EN (see pc_next_calc).
//   state    | meaning
//   ST_RST   | reset held, no request, nothing issued
//   ST_FETCH | read request at PC, waiting for busywait low
//   ST_ISSUE | fields valid from instruction register, held while stalled
module instruction_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    instruction_fetch_unit_if.master  imem,
    input  logic                      stall_i,
    input  logic                      branch_taken_i,
    input  logic [7:0]                branch_offset_i,
    output logic [31:0]               pc_o,
    output logic                      instr_valid_o,
    output logic [7:0]                opcode_o,
    output logic [7:0]                dest_o,
    output logic [7:0]                src1_o,
    output logic [7:0]                src2_o
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] next_pc;
    logic        read_d;
    logic        valid_d;

    pc_next_calc #(.PC_STEP(PC_STEP)) u_pc_next_calc (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken_i),
        .branch_offset_i (branch_offset_i),
        .next_pc_o       (next_pc)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        read_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                read_d = 1'b1;
                if (!imem.busywait) begin
                    ir_d    = imem.readdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                valid_d = 1'b1;
                // Branch is only sampled on the edge that ends the issue, so a stalled branch is deferred.
                if (!stall_i) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign imem.read     = read_d;
    assign imem.addr     = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_d;
    assign opcode_o      = ir_q[OPC_MSB:OPC_LSB];
    assign dest_o        = ir_q[DEST_MSB:DEST_LSB];
    assign src1_o        = ir_q[SRC1_MSB:SRC1_LSB];
    assign src2_o        = ir_q[SRC2_MSB:SRC2_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an issue scoreboard.
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        rst, rst2;
    logic        bw, bw2;
    logic        stall, stall2;
    logic        bt;
    logic [7:0]  bo;
    logic [31:0] pc1, pc2;
    logic        v1, v2;
    logic [7:0]  opc1, dst1, sa1, sb1;
    logic [7:0]  opc2, dst2, sa2, sb2;
    logic [31:0] mem [0:15];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if bus1();
    instruction_fetch_unit_if bus2();

    assign bus1.busywait = bw;
    assign bus1.readdata = mem[bus1.addr[5:2]];
    assign bus2.busywait = bw2;
    assign bus2.readdata = mem[bus2.addr[5:2]];

    instruction_fetch_unit dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .imem            (bus1),
        .stall_i         (stall),
        .branch_taken_i  (bt),
        .branch_offset_i (bo),
        .pc_o            (pc1),
        .instr_valid_o   (v1),
        .opcode_o        (opc1),
        .dest_o          (dst1),
        .src1_o          (sa1),
        .src2_o          (sb1)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i           (clk),
        .reset_i         (rst2),
        .imem            (bus2),
        .stall_i         (stall2),
        .branch_taken_i  (1'b0),
        .branch_offset_i (8'h00),
        .pc_o            (pc2),
        .instr_valid_o   (v2),
        .opcode_o        (opc2),
        .dest_o          (dst2),
        .src1_o          (sa2),
        .src2_o          (sb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_issue(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem[pc[5:2]];
        sb.push_back(e);
    endtask

    task automatic check_issue(input string tag);
        exp_t e;
        chk({tag, "_valid"}, {31'd0, v1}, 32'd1);
        chk({tag, "_read"}, {31'd0, bus1.read}, 32'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=unexpected_issue expected=none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"},     pc1,           e.pc);
            chk({tag, "_opcode"}, {24'd0, opc1}, {24'd0, e.word[31:24]});
            chk({tag, "_dest"},   {24'd0, dst1}, {24'd0, e.word[23:16]});
            chk({tag, "_src1"},   {24'd0, sa1},  {24'd0, e.word[15:8]});
            chk({tag, "_src2"},   {24'd0, sb1},  {24'd0, e.word[7:0]});
        end
    endtask

    initial begin
        logic [31:0] exp_br;
        int n;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0004_0009;
        mem[1]  = 32'h0203_0102;
        mem[2]  = 32'h0501_0203;
        mem[3]  = 32'h0102_0304;
        mem[15] = 32'h03AA_BBCC;
        rst = 1'b1; rst2 = 1'b1;
        bw = 1'b0; bw2 = 1'b0;
        stall = 1'b0; stall2 = 1'b0;
        bt = 1'b0; bo = 8'h00;

        // Reset state
        step();
        chk("rst_pc",     pc1, 32'h0);
        chk("rst_read",   {31'd0, bus1.read}, 32'd0);
        chk("rst_valid",  {31'd0, v1}, 32'd0);
        chk("rst_opcode", {24'd0, opc1}, 32'd0);
        chk("rst_addr",   bus1.addr, 32'h0);
        chk("rst2_pc",    pc2, 32'hFFFF_FFFC);
        chk("rst2_read",  {31'd0, bus2.read}, 32'd0);
        step();
        rst = 1'b0;
        push_issue(32'h0);

        // First fetch and issue
        step();
        chk("fetch0_read",  {31'd0, bus1.read}, 32'd1);
        chk("fetch0_addr",  bus1.addr, 32'h0);
        chk("fetch0_valid", {31'd0, v1}, 32'd0);
        step();
        check_issue("issue0");
        step();
        chk("fetch1_addr", bus1.addr, 32'h4);
        chk("fetch1_read", {31'd0, bus1.read}, 32'd1);

        // Busywait held for five edges
        bw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bw_read",  {31'd0, bus1.read}, 32'd1);
            chk("bw_valid", {31'd0, v1}, 32'd0);
            chk("bw_addr",  bus1.addr, 32'h4);
        end
        bw = 1'b0;
        push_issue(32'h4);

        // Stall three cycles during issue
        step();
        check_issue("issue1");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid",  {31'd0, v1}, 32'd1);
            chk("stall_pc",     pc1, 32'h4);
            chk("stall_opcode", {24'd0, opc1}, 32'h02);
            chk("stall_src2",   {24'd0, sb1}, 32'h02);
        end
        stall = 1'b0;
        step();
        chk("post_stall_pc",    pc1, 32'h8);
        chk("post_stall_valid", {31'd0, v1}, 32'd0);
        chk("post_stall_addr",  bus1.addr, 32'h8);
        push_issue(32'h8);

        // Branch taken with offset -2 words at PC=8
        step();
        check_issue("issue2");
        bt = 1'b1;
        bo = 8'hFE;
`ifdef IFU_BRANCH_EN
        exp_br = 32'h4;
`else
        exp_br = 32'hC;
`endif
        step();
        chk("branch_pc",    pc1, exp_br);
        chk("branch_addr",  bus1.addr, exp_br);
        chk("branch_valid", {31'd0, v1}, 32'd0);
        bt = 1'b0;
        bo = 8'h00;

        // Reset in the second cycle of a busywait fetch
        bw = 1'b1;
        step();
        chk("midfetch_read", {31'd0, bus1.read}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_read",   {31'd0, bus1.read}, 32'd0);
        chk("midrst_pc",     pc1, 32'h0);
        chk("midrst_valid",  {31'd0, v1}, 32'd0);
        chk("midrst_opcode", {24'd0, opc1}, 32'd0);
        chk("midrst_dest",   {24'd0, dst1}, 32'd0);
        rst = 1'b0;
        bw = 1'b0;

        // Back-to-back issues: one instruction per two cycles
        push_issue(32'h0);
        push_issue(32'h4);
        push_issue(32'h8);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!v1 && n < 8);
            if (!v1) begin
                checks++;
                errors++;
                $error("FAIL b2b_timeout observed=no_issue expected=issue");
            end else begin
                check_issue("b2b");
                chk("b2b_gap", n, 2);
            end
        end

        // PC wrap from 0xFFFFFFFC
        rst2 = 1'b0;
        step();
        chk("wrap_fetch_addr", bus2.addr, 32'hFFFF_FFFC);
        chk("wrap_fetch_read", {31'd0, bus2.read}, 32'd1);
        step();
        chk("wrap_valid",  {31'd0, v2}, 32'd1);
        chk("wrap_pc",     pc2, 32'hFFFF_FFFC);
        chk("wrap_fields", {opc2, dst2, sa2, sb2}, 32'h03AA_BBCC);
        step();
        chk("wrap_next_addr", bus2.addr, 32'h0000_0000);
        chk("wrap_next_read", {31'd0, bus2.read}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
